regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_SRC writeback producers, e.g. ALU, load unit and mul/div.
- Each source has a small request FIFO.
- A round-robin arbiter drains one FIFO head per cycle onto wr_en/wr_addr/wr_data.
- Also exports a pending-write mask so decode can stall on registers with queued writes. Sits between execute/memory stages and the register file.

Parameters:
- NUM_SRC, 3, number of writeback requesters (2..4)
- FIFO_DEPTH, 2, entries per source FIFO (power of two, 2..8)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- src_valid  input  NUM_SRC  per-source write request valid
- src_ready  output  NUM_SRC  per-source FIFO can accept
- src_addr  input  NUM_SRC*5  destination register; source i in bits [5i+4:5i]
- src_data  input  NUM_SRC*32  write data; source i in bits [32i+31:32i]
- wr_en  output  1  register file write enable
- wr_addr  output  5  register file write address
- wr_data  output  32  register file write data
- pending_mask  output  32  bit r set while any FIFO holds a write to xr
- grant_onehot  output  NUM_SRC  source being drained this cycle, for debug/perf

Behaviour:
- Clock is clk; reset rst_n is asynchronous, active-low. Fixed.
- Reset clears all FIFO pointers/counts and sets rr_ptr = 0.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, grant_onehot=0, pending_mask=0, src_ready=all ones.
- Reset mid-operation discards all queued writes; none reach the register file.
- Enqueue: handshake on src_valid[i] && src_ready[i] at the rising edge.
  - src_ready[i] = !full[i], registered-state only.
  - src_ready does not depend on a same-cycle dequeue, so there is no combinational path from the grant.
- src_addr == 0: handshake completes but the entry is not stored (x0 is hardwired).
- Dequeue/arbitration: combinational over nonempty FIFO heads.
  - Search order starts at rr_ptr, wraps modulo NUM_SRC.
  - The first nonempty source i wins: grant_onehot[i]=1, wr_en=1, wr_addr/wr_data = head of FIFO i.
  - At the edge, FIFO i pops and rr_ptr <= (i+1) mod NUM_SRC.
  - With no nonempty FIFO: wr_en=0, wr_addr=0, wr_data=0, rr_ptr unchanged.
- Latency: a request accepted at edge N is visible on wr_* at the earliest in the cycle after edge N. It is written into the register file at edge N+1.
- Throughput: one write per cycle total.
- Fairness: with all sources continuously busy, each is granted once every NUM_SRC cycles.
- Enqueue and pop on the same FIFO in the same cycle are both honoured; count is unchanged.
  - If count == 1 in that case, the FIFO is nonempty the next cycle with the new entry at the head.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- pending_mask is combinational OR over all valid entries of all FIFOs: bit src_addr set per valid entry. Bit 0 is always 0.
- An entry being popped this cycle still counts as pending. Together with the register file's same-cycle write forwarding, this is conservative and safe.
- Ordering:
  - Order is guaranteed within one source.
  - Across sources there is no ordering guarantee. Producers must not issue a write to a register whose pending_mask bit is set from a different source; decode enforces this.
- Enqueue on a full FIFO cannot occur by the handshake definition. src_valid while not ready is held by the producer.

Optional Feature:
- Macro WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index highest. rr_ptr is removed, and the search always starts at source 0.
- Undefined (default): round-robin as described.
- Everything else is identical either way: enqueue/dequeue rules, pending_mask, reset.

Test Plan:
- Reset with all src_valid=1 held → while rst_n=0: wr_en=0, pending_mask=0, src_ready=3'b111. After release, the first write appears one cycle after the first accepting edge.
- Single write: source 0 writes x5=0xDEADBEEF → next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_onehot=3'b001. pending_mask[5]=1 until after that edge, then 0.
- Round-robin: all three sources each enqueue 2 writes (x1..x6) in the same two cycles → grant sequence 0,1,2,0,1,2 over six consecutive cycles. With WB_ARB_FIXED_PRIO_EN the sequence is 0,0,1,1,2,2.
- Backpressure: source 1 enqueues 3 back-to-back while sources 0 and 2 stream continuously (DEPTH=2) → src_ready[1] drops after 2 accepted. The third is accepted only after source 1's first grant, and the data order is preserved.
- x0 drop: source 2 writes x0=0x1234 → handshake completes, no wr_en pulse, pending_mask stays 0.
- Async reset mid-stream: assert rst_n low between edges with 4 entries queued → wr_en=0 and pending_mask=0 immediately. None of the queued writes appear after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: per-source writeback FIFOs drained one head per cycle onto the register file write port.
// Round-robin by default; define WB_ARB_FIXED_PRIO_EN for fixed priority (source 0 highest).
module regfile_wb_arbiter #(
   parameter int NUM_SRC    = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC-1:0]    src_valid,
   output logic [NUM_SRC-1:0]    src_ready,
   input  logic [NUM_SRC*5-1:0]  src_addr,
   input  logic [NUM_SRC*32-1:0] src_data,
   output logic                  wr_en,
   output logic [4:0]            wr_addr,
   output logic [31:0]           wr_data,
   output logic [31:0]           pending_mask,
   output logic [NUM_SRC-1:0]    grant_onehot
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(NUM_SRC);

   logic [4:0]         addr_mem [NUM_SRC][FIFO_DEPTH];
   logic [31:0]        data_mem [NUM_SRC][FIFO_DEPTH];
   logic [AW-1:0]      rd_ptr [NUM_SRC];
   logic [AW-1:0]      wr_ptr [NUM_SRC];
   logic [CW-1:0]      count [NUM_SRC];
   logic [NUM_SRC-1:0] nonempty;
   logic [NUM_SRC-1:0] push;
   logic [SW-1:0]      win;
   logic [SW-1:0]      idx;
   int                 s;
`ifndef WB_ARB_FIXED_PRIO_EN
   logic [SW-1:0]      rr_ptr;
`endif

   // x0 writes complete the handshake but are never stored
   always_comb begin
      nonempty  = '0;
      src_ready = '0;
      push      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         nonempty[i]  = count[i] != '0;
         src_ready[i] = count[i] != CW'(FIFO_DEPTH);
         push[i]      = src_valid[i] && src_ready[i] && src_addr[5*i +: 5] != 5'd0;
      end
   end

   // Scan in reverse search order so the last hit is the first source in search order
   always_comb begin
      win = '0;
      idx = '0;
      s   = 0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         s = k;
`else
         s = int'(rr_ptr) + k;
         if (s >= NUM_SRC) s = s - NUM_SRC;
`endif
         idx = SW'(s);
         if (nonempty[idx]) win = idx;
      end
      wr_en        = |nonempty;
      grant_onehot = wr_en ? (NUM_SRC'(1) << win) : '0;
      wr_addr      = wr_en ? addr_mem[win][rd_ptr[win]] : 5'd0;
      wr_data      = wr_en ? data_mem[win][rd_ptr[win]] : 32'd0;
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < NUM_SRC; i++)
         for (int j = 0; j < FIFO_DEPTH; j++)
            if (CW'(j) < count[i]) pending_mask[addr_mem[i][rd_ptr[i] + AW'(j)]] = 1'b1;
      pending_mask[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (grant_onehot[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
            count[i] <= count[i] + CW'(push[i]) - CW'(grant_onehot[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++)
         if (push[i]) begin
            addr_mem[i][wr_ptr[i]] <= src_addr[5*i +: 5];
            data_mem[i][wr_ptr[i]] <= src_data[32*i +: 32];
         end
   end

`ifndef WB_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr <= '0;
      else if (wr_en) rr_ptr <= (win == SW'(NUM_SRC - 1)) ? '0 : win + SW'(1);
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed tables, corner sequences and random traffic against a queue-based model.
module tb_regfile_wb_arbiter;
   localparam int N = 3;
   localparam int D = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    src_valid, src_ready, grant_onehot;
   logic [14:0]   src_addr;
   logic [95:0]   src_data;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [31:0]   wr_data, pending_mask;

   int            total = 0;
   int            bad = 0;
   int            qa [N][$];
   logic [31:0]   qd [N][$];
   int            rr = 0;
   int            g_now = -1;

   typedef struct {
      logic [2:0]  v;
      logic [14:0] a;
      logic [95:0] d;
      logic        en;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [2:0]  gr;
      logic [31:0] pm;
   } vec_t;
   vec_t vecs [4];

   regfile_wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
      .src_addr(src_addr), .src_data(src_data), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .pending_mask(pending_mask), .grant_onehot(grant_onehot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         qa[i].delete();
         qd[i].delete();
      end
      rr = 0;
      g_now = -1;
   endtask

   task automatic check_model();
      logic [31:0] pm = '0;
      logic [2:0]  rdy = '0;
      int          g = -1;
      int          s;
      for (int k = 0; k < N; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         s = k;
`else
         s = (rr + k) % N;
`endif
         if (g < 0 && qa[s].size() > 0) g = s;
         rdy[k] = qa[k].size() < D;
         for (int j = 0; j < qa[k].size(); j++) pm[qa[k][j]] = 1'b1;
      end
      g_now = g;
      chk("ready", {29'd0, src_ready}, {29'd0, rdy});
      chk("wr_en", {31'd0, wr_en}, (g >= 0) ? 32'd1 : 32'd0);
      chk("wr_addr", {27'd0, wr_addr}, (g >= 0) ? qa[g][0] : 0);
      chk("wr_data", wr_data, (g >= 0) ? qd[g][0] : 32'd0);
      chk("grant", {29'd0, grant_onehot}, (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("pending", pending_mask, pm);
   endtask

   task automatic update_model();
      for (int i = 0; i < N; i++)
         if (src_valid[i] && qa[i].size() < D && src_addr[5*i +: 5] != 5'd0) begin
            qa[i].push_back(int'(src_addr[5*i +: 5]));
            qd[i].push_back(src_data[32*i +: 32]);
         end
      if (g_now >= 0) begin
         void'(qa[g_now].pop_front());
         void'(qd[g_now].pop_front());
         rr = (g_now + 1) % N;
      end
   endtask

   task automatic apply(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d);
      @(negedge clk);
      src_valid = v;
      src_addr  = a;
      src_data  = d;
      #1;
      check_model();
   endtask

   task automatic advance();
      @(posedge clk);
      update_model();
   endtask

   task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d);
      apply(v, a, d);
      advance();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      src_valid = '0;
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [95:0] rnd96();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [2:0] eg [6];
      logic [4:0] ea [6];
`ifdef WB_ARB_FIXED_PRIO_EN
      eg = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
      ea = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
`else
      eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      ea = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
`endif
      vecs[0] = '{3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, 5'd0, 32'd0, 3'b000, 32'd0};
      vecs[1] = '{3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 32'hDEADBEEF, 3'b001, 32'h20};
      vecs[2] = '{3'b100, 15'd0, {32'h1234, 64'd0}, 1'b0, 5'd0, 32'd0, 3'b000, 32'd0};
      vecs[3] = '{3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 32'd0, 3'b000, 32'd0};

      // Reset held with every source requesting
      src_valid = 3'b111;
      src_addr  = {5'd3, 5'd2, 5'd1};
      src_data  = rnd96();
      reset_model();
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
         chk("rst_pending", pending_mask, 32'd0);
         chk("rst_ready", {29'd0, src_ready}, 32'd7);
         chk("rst_grant", {29'd0, grant_onehot}, 32'd0);
         chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
         chk("rst_wr_data", wr_data, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_model();
      chk("first_no_write", {31'd0, wr_en}, 32'd0);
      advance();
      apply(3'b000, 15'd0, 96'd0);
      chk("first_write", {31'd0, wr_en}, 32'd1);
      chk("first_grant", {29'd0, grant_onehot}, 32'd1);
      advance();
      repeat (4) step(3'b000, 15'd0, 96'd0);

      // Single write and x0 drop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(vecs[i].v, vecs[i].a, vecs[i].d);
         chk("tbl_wr_en", {31'd0, wr_en}, {31'd0, vecs[i].en});
         chk("tbl_wr_addr", {27'd0, wr_addr}, {27'd0, vecs[i].wa});
         chk("tbl_wr_data", wr_data, vecs[i].wd);
         chk("tbl_grant", {29'd0, grant_onehot}, {29'd0, vecs[i].gr});
         chk("tbl_pending", pending_mask, vecs[i].pm);
         advance();
      end

      // Arbitration order with all sources loaded
      do_reset();
      step(3'b111, {5'd3, 5'd2, 5'd1}, rnd96());
      for (int k = 0; k < 6; k++) begin
         apply((k == 0) ? 3'b111 : 3'b000, (k == 0) ? {5'd6, 5'd5, 5'd4} : 15'd0, rnd96());
         chk("arb_grant", {29'd0, grant_onehot}, {29'd0, eg[k]});
         chk("arb_addr", {27'd0, wr_addr}, {27'd0, ea[k]});
         advance();
      end

      // Backpressure on source 1 while neighbours stream
      do_reset();
      step(3'b111, {5'd12, 5'd7, 5'd10}, rnd96());
      step(3'b111, {5'd13, 5'd8, 5'd11}, rnd96());
      apply(3'b111, {5'd14, 5'd9, 5'd10}, rnd96());
`ifndef WB_ARB_FIXED_PRIO_EN
      chk("bp_ready1_low", {31'd0, src_ready[1]}, 32'd0);
      chk("bp_grant1", {29'd0, grant_onehot}, 32'd2);
`endif
      advance();
      apply(3'b111, {5'd15, 5'd9, 5'd11}, src_data);
`ifndef WB_ARB_FIXED_PRIO_EN
      chk("bp_ready1_back", {31'd0, src_ready[1]}, 32'd1);
`endif
      advance();
      repeat (8) step(3'b000, 15'd0, 96'd0);

      // Asynchronous reset with four entries queued
      do_reset();
      step(3'b111, {5'd3, 5'd2, 5'd1}, rnd96());
      step(3'b011, {5'd0, 5'd5, 5'd4}, rnd96());
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_wr_en", {31'd0, wr_en}, 32'd0);
      chk("ar_pending", pending_mask, 32'd0);
      chk("ar_ready", {29'd0, src_ready}, 32'd7);
      chk("ar_grant", {29'd0, grant_onehot}, 32'd0);
      reset_model();
      src_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step(3'b000, 15'd0, 96'd0);

      // Random traffic
      do_reset();
      repeat (400) step(3'($urandom), 15'($urandom), rnd96());
      repeat (8) step(3'b000, 15'd0, 96'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
